gf2m_reduce_seq: RTL and testbench

//  Parametrised, multi-cycle GF(2^M) polynomial reduction modulo P(x)=x^M+x^K1+x^K2+x^K3+1.

---
 rtl/gf2m_pkg.sv | 45 ++++
 rtl/gf2m_fold_step.sv | 47 ++++
 rtl/gf2m_reduce_seq.sv | 106 ++++++++++
 tb/tb_gf2m_reduce_seq.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf2m_pkg.sv
// Shared GF(2^m) definitions: NIST binary field polynomials, fold-count helpers
// and the reduction FSM state type.
package gf2m_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FOLD,
    DONE
  } state_t;

  // P(x) = x^M + x^K1 + x^K2 + x^K3 + 1; trinomials carry K2 = K3 = 0
  localparam int unsigned B163_M  = 163;
  localparam int unsigned B163_K1 = 7;
  localparam int unsigned B163_K2 = 6;
  localparam int unsigned B163_K3 = 3;

  localparam int unsigned B233_M  = 233;
  localparam int unsigned B233_K1 = 74;
  localparam int unsigned B233_K2 = 0;
  localparam int unsigned B233_K3 = 0;

  localparam int unsigned B283_M  = 283;
  localparam int unsigned B283_K1 = 12;
  localparam int unsigned B283_K2 = 7;
  localparam int unsigned B283_K3 = 5;

  localparam int unsigned B409_M  = 409;
  localparam int unsigned B409_K1 = 87;
  localparam int unsigned B409_K2 = 0;
  localparam int unsigned B409_K3 = 0;

  localparam int unsigned B571_M  = 571;
  localparam int unsigned B571_K1 = 10;
  localparam int unsigned B571_K2 = 5;
  localparam int unsigned B571_K3 = 2;

  function automatic int unsigned nfold(input int unsigned m, input int unsigned fold_w);
    return (m - 1 + fold_w - 1) / fold_w;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gf2m_fold_step.sv
// Combinational single-chunk fold: clears excess bits W[hi:lo] and XORs their
// images under x^M = x^K1 + x^K2 + x^K3 + 1 into lower positions.
module gf2m_fold_step
  import gf2m_pkg::*;
#(
  parameter int unsigned M      = 571,
  parameter int unsigned K1     = 10,
  parameter int unsigned K2     = 5,
  parameter int unsigned K3     = 2,
  parameter int unsigned FOLD_W = 64,
  parameter int unsigned CW     = 4
) (
  input  logic [2*M-2:0] w,
  input  logic [CW-1:0]  idx,
  output logic [2*M-2:0] w_next,
  output logic           excess_zero
);

  localparam int unsigned WW   = 2*M - 1;
  localparam int unsigned NF   = nfold(M, FOLD_W);
  localparam logic [WW-1:0] ONES = '1;

  int unsigned   hi;
  int unsigned   lo;
  int unsigned   sh;
  logic [WW-1:0] mask;
  logic [WW-1:0] chunk;

  // All chunk bits fold at once: FOLD_W <= M-K1 keeps every target below lo,
  // so no target can land back inside the chunk being cleared. With K2=K3=0
  // the three coincident XORs at x^0 cancel to a single flip.
  always_comb begin
    hi = WW - 1;
    if (32'(idx) < NF) hi = WW - 1 - 32'(idx) * FOLD_W;
    lo = (hi + 1 >= M + FOLD_W) ? hi + 1 - FOLD_W : M;
    sh = lo - M;
    mask  = (ONES >> (WW - 1 - hi)) & (ONES << lo);
    chunk = (w & mask) >> lo;
    w_next = (w & ~mask)
           ^ (chunk << sh)
           ^ (chunk << (sh + K3))
           ^ (chunk << (sh + K2))
           ^ (chunk << (sh + K1));
    excess_zero = ~|w_next[WW-1:M];
  end

endmodule

// File: rtl/gf2m_reduce_seq.sv
// Multi-cycle GF(2^M) reduction of a 2M-1 bit carry-less product, FOLD_W
// excess bits per cycle, valid/ready on both sides.
module gf2m_reduce_seq
  import gf2m_pkg::*;
#(
  parameter int unsigned M          = 571,
  parameter int unsigned K1         = 10,
  parameter int unsigned K2         = 5,
  parameter int unsigned K3         = 2,
  parameter int unsigned FOLD_W     = 64,
  parameter int unsigned CONST_TIME = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*M-2:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M-1:0]   out_data,
  output logic           busy
);

  localparam int unsigned NFOLD = nfold(M, FOLD_W);
  localparam int unsigned CW    = cnt_width(NFOLD);
  localparam logic [CW-1:0] LAST = CW'(NFOLD - 1);

  if (M <= K1) begin : g_bad_m
    $error("gf2m_reduce_seq: M must exceed K1");
  end
  if (FOLD_W < 1 || FOLD_W > M - K1) begin : g_bad_fold_w
    $error("gf2m_reduce_seq: FOLD_W must lie in 1..M-K1");
  end
  if (!((K1 > K2 && K2 > K3 && K3 > 0) || (K2 == 0 && K3 == 0 && K1 > 0))) begin : g_bad_k
    $error("gf2m_reduce_seq: need K1>K2>K3>0 or a trinomial with K2=K3=0");
  end

  state_t         state;
  logic [2*M-2:0] w;
  logic [2*M-2:0] w_next;
  logic [CW-1:0]  cnt;
  logic           excess_zero;

  gf2m_fold_step #(
    .M      (M),
    .K1     (K1),
    .K2     (K2),
    .K3     (K3),
    .FOLD_W (FOLD_W),
    .CW     (CW)
  ) u_fold (
    .w           (w),
    .idx         (cnt),
    .w_next      (w_next),
    .excess_zero (excess_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      w         <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            w        <= in_data;
            cnt      <= '0;
            state    <= FOLD;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        FOLD: begin
          w <= w_next;
          if (cnt == LAST || (CONST_TIME == 0 && excess_zero)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_data  <= w_next[M-1:0];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf2m_reduce_seq.sv
// Scoreboard bench for gf2m_reduce_seq over several field/fold-width configurations,
// checked against polynomial long division.
module tb_gf2m_reduce_seq;

  localparam int NI = 5;
  localparam int CM  [NI] = '{571, 571, 571, 571, 233};
  localparam int CK1 [NI] = '{10, 10, 10, 10, 74};
  localparam int CK2 [NI] = '{5, 5, 5, 5, 0};
  localparam int CK3 [NI] = '{2, 2, 2, 2, 0};

  logic clk = 1'b0;
  logic rst;
  logic iv [NI];
  logic ir [NI];
  logic ov [NI];
  logic ordy [NI];
  logic bz [NI];
  logic [1140:0] din [NI];
  logic [570:0]  dout [NI];
  logic [232:0]  d233;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [570:0] expq [NI][$];
  logic [570:0] mon_exp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gf2m_reduce_seq #(.M(571), .K1(10), .K2(5), .K3(2), .FOLD_W(64), .CONST_TIME(1)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(din[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(dout[0]), .busy(bz[0]));
  gf2m_reduce_seq #(.M(571), .K1(10), .K2(5), .K3(2), .FOLD_W(1), .CONST_TIME(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(din[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(dout[1]), .busy(bz[1]));
  gf2m_reduce_seq #(.M(571), .K1(10), .K2(5), .K3(2), .FOLD_W(7), .CONST_TIME(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(din[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(dout[2]), .busy(bz[2]));
  gf2m_reduce_seq #(.M(571), .K1(10), .K2(5), .K3(2), .FOLD_W(561), .CONST_TIME(0)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .in_data(din[3]),
    .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(dout[3]), .busy(bz[3]));
  gf2m_reduce_seq #(.M(233), .K1(74), .K2(0), .K3(0), .FOLD_W(32), .CONST_TIME(1)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv[4]), .in_ready(ir[4]), .in_data(din[4][464:0]),
    .out_valid(ov[4]), .out_ready(ordy[4]), .out_data(d233), .busy(bz[4]));
  assign dout[4] = 571'(d233);

  // Reference: textbook long division by P(x), highest excess term first.
  function automatic logic [570:0] ref_reduce(input logic [1140:0] a, input int i);
    logic [1140:0] r;
    logic [1140:0] p;
    r = a;
    p = '0;
    p[CM[i]] = 1'b1;
    p[CK1[i]] = p[CK1[i]] ^ 1'b1;
    p[CK2[i]] = p[CK2[i]] ^ 1'b1;
    p[CK3[i]] = p[CK3[i]] ^ 1'b1;
    p[0] = p[0] ^ 1'b1;
    for (int k = 2*CM[i]-2; k >= CM[i]; k--)
      if (r[k]) r = r ^ (p << (k - CM[i]));
    return r[570:0];
  endfunction

  function automatic logic [1140:0] rnd(input int i);
    logic [1140:0] v;
    v = '0;
    if ($urandom_range(0, 3) == 0) begin
      v[$urandom_range(0, 2*CM[i]-2)] = 1'b1;
    end else begin
      for (int j = 0; j < 36; j++) v = (v << 32) | 1141'($urandom);
      v = v & ((1141'(1) << (2*CM[i]-1)) - 1141'(1));
    end
    return v;
  endfunction

  function automatic logic [1140:0] xpow(input int n);
    logic [1140:0] v;
    v = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired, got no event, required one", name);
    summary();
    $finish;
    forever #10;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic chk_v(input string name, input logic [570:0] act, input logic [570:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic accept(input int i, input logic [1140:0] d, output int acc_cyc);
    bit got;
    int guard;
    got = 1'b0;
    guard = 0;
    din[i] = d;
    iv[i] = 1'b1;
    while (!got) begin
      @(negedge clk);
      got = ir[i];
      @(posedge clk);
      #1;
      guard++;
      if (guard > 5000) timeout("accept");
    end
    acc_cyc = cyc;
    iv[i] = 1'b0;
    expq[i].push_back(ref_reduce(d, i));
  endtask

  task automatic wait_out(input int i, output int lat);
    lat = 0;
    while (!ov[i]) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat > 5000) timeout("wait_out");
    end
  endtask

  task automatic send(input int i, input logic [1140:0] d, output int lat);
    int ac;
    accept(i, d, ac);
    wait_out(i, lat);
  endtask

  // Monitor: every output handshake pops one expected result.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NI; i++) begin
        if (ov[i] && ordy[i]) begin
          n_cmp++;
          if (expq[i].size() == 0) begin
            n_bad++;
            $display("FAIL out%0d: unexpected result %h, required none", i, dout[i]);
          end else begin
            mon_exp = expq[i].pop_front();
            if (dout[i] !== mon_exp) begin
              n_bad++;
              $display("FAIL out%0d: got %h required %h", i, dout[i], mon_exp);
            end
          end
        end
      end
    end
  end

  initial begin
    int lat;
    int ac;
    int hs;
    int changes;
    int irbad;
    int guard;
    logic [570:0] e;
    logic [570:0] held;

    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      iv[i] = 1'b0;
      ordy[i] = 1'b1;
      din[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", ir[0], 1);
    chk("reset out_valid", ov[0], 0);
    chk("reset busy", bz[0], 0);
    chk_v("reset out_data", dout[0], '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // x^571 -> x^10+x^5+x^2+1, latency NFOLD=9
    send(0, xpow(571), lat);
    chk("t1 latency", lat, 9);
    e = '0; e[10] = 1; e[5] = 1; e[2] = 1; e[0] = 1;
    chk_v("t1 data", dout[0], e);

    // x^1140 = x^569 * x^571 -> x^569+x^18+x^3+x^2+1
    send(0, xpow(1140), lat);
    e = '0; e[569] = 1; e[18] = 1; e[3] = 1; e[2] = 1; e[0] = 1;
    chk_v("t2 data", dout[0], e);

    send(0, '0, lat);
    chk("t6 latency zero", lat, 9);
    send(0, '1, lat);
    chk("t6 latency ones", lat, 9);

    send(3, xpow(600), lat);
    chk("t6 early-exit latency", lat, 1);
    e = '0; e[39] = 1; e[34] = 1; e[31] = 1; e[29] = 1;
    chk_v("t6 early-exit data", dout[3], e);

    send(4, xpow(233), lat);
    chk("trinomial latency", lat, 8);
    e = '0; e[74] = 1; e[0] = 1;
    chk_v("trinomial data", dout[4], e);

    for (int n = 0; n < 20; n++) begin send(0, rnd(0), lat); chk("rand w64 latency", lat, 9); end
    for (int n = 0; n < 3; n++)  begin send(1, rnd(1), lat); chk("rand w1 latency", lat, 570); end
    for (int n = 0; n < 6; n++)  begin send(2, rnd(2), lat); chk("rand w7 latency", lat, 82); end
    for (int n = 0; n < 10; n++) send(3, rnd(3), lat);
    for (int n = 0; n < 10; n++) send(4, rnd(4), lat);

    // Backpressure: DONE held, data stable, no accept while out_ready low
    ordy[0] = 1'b0;
    send(0, rnd(0), lat);
    held = dout[0];
    changes = 0;
    irbad = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (dout[0] !== held) changes++;
      if (ir[0] !== 1'b0) irbad++;
    end
    chk("t4 data changes", changes, 0);
    chk("t4 in_ready high cycles", irbad, 0);
    chk("t4 out_valid held", ov[0], 1);
    ordy[0] = 1'b1;
    @(negedge clk);
    chk("t4 in_ready in out_ready cycle", ir[0], 0);
    @(posedge clk);
    #1;
    hs = cyc;
    chk("t4 out_valid after handshake", ov[0], 0);
    chk("t4 in_ready after handshake", ir[0], 1);
    accept(0, rnd(0), ac);
    chk("t4 accept edge offset", ac - hs, 1);
    wait_out(0, lat);
    chk("t4 next latency", lat, 9);

    // Async reset in the middle of folding
    accept(0, rnd(0), ac);
    repeat (4) @(posedge clk);
    #2;
    chk("t5 busy mid-fold", bz[0], 1);
    rst = 1'b1;
    #1;
    chk("t5 out_valid on reset", ov[0], 0);
    chk("t5 in_ready on reset", ir[0], 1);
    chk("t5 busy on reset", bz[0], 0);
    expq[0].delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    send(0, rnd(0), lat);
    chk("t5 post-reset latency", lat, 9);

    guard = 0;
    while (expq[0].size() + expq[1].size() + expq[2].size() + expq[3].size() + expq[4].size() != 0) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 100) timeout("drain");
    end
    summary();
    $finish;
  end

endmodule
